// File: rtl/packet_arbiter_pkg.sv
// packet_arbiter_pkg: state encoding and default sizing for packet_arbiter.
package packet_arbiter_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
  localparam int DEFAULT_NUM_SOURCES = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;
  localparam int GRANT_WIDTH = $clog2(DEFAULT_NUM_SOURCES);
endpackage

// File: rtl/packet_pkg.sv
// packet_pkg: beat geometry shared by the packet datapath blocks.
package packet_pkg;
  localparam int packet_width_bits = 32;
  localparam int byte_enable_width_bits = packet_width_bits / 8;
endpackage

// File: rtl/packet_arbiter_picker.sv
// round_robin_picker: combinational pick of the first requester after last_grant, with wrap.
module round_robin_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] request,
  input  logic [W-1:0] last_grant,
  output logic [W-1:0] grant,
  output logic         any_request
);
  logic [W-1:0] idx;
  always_comb begin
    grant = last_grant;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(last_grant) + k) % N);
      grant = request[idx] ? idx : grant;
    end
  end
  assign any_request = |request;
endmodule

// File: rtl/packet_arbiter.sv
// packet_arbiter: packet-granular round-robin arbiter feeding payload_aligner; PACKET_ARBITER_TIMEOUT_EN adds a stall watchdog and oTimeout.
module packet_arbiter
  import packet_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES = DEFAULT_NUM_SOURCES,
  parameter int DATA_WIDTH = packet_pkg::packet_width_bits,
  parameter int BE_WIDTH = packet_pkg::byte_enable_width_bits,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                             iClk,
  input  logic                             iReset,
  input  logic [NUM_SOURCES-1:0]           iValid,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] iPacket,
  input  logic [NUM_SOURCES-1:0]           iSop,
  input  logic [NUM_SOURCES-1:0]           iEop,
  input  logic [NUM_SOURCES*BE_WIDTH-1:0]  iByte_enable,
  output logic [NUM_SOURCES-1:0]           oReady,
  output logic                             oValid,
  output logic [DATA_WIDTH-1:0]            oPacket,
  output logic                             oSop,
  output logic                             oEop,
  output logic [BE_WIDTH-1:0]              oByte_enable,
  output logic [$clog2(NUM_SOURCES)-1:0]   oGrant,
`ifdef PACKET_ARBITER_TIMEOUT_EN
  output logic                             oTimeout,
`endif
  output logic                             oProtocol_err
);
  localparam int GW = $clog2(NUM_SOURCES);
  arb_state_t state;
  logic [GW-1:0] last_grant, pick;
  logic any_request, first, xfer, src_sop, src_eop;
  logic [DATA_WIDTH-1:0] src_packet;
  logic [BE_WIDTH-1:0] src_be;
  if (NUM_SOURCES < 2 || NUM_SOURCES > 16 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_params
    $error("packet_arbiter: parameter out of range");
  end
  round_robin_picker #(.N(NUM_SOURCES), .W(GW)) u_picker (
    .request(iValid & iSop),
    .last_grant(last_grant),
    .grant(pick),
    .any_request(any_request)
  );
  // while locked, last_grant is the source that owns the stream
  assign xfer = (state == ARB_LOCKED) && iValid[last_grant];
  assign src_sop = iSop[last_grant];
  assign src_eop = iEop[last_grant];
  assign src_packet = DATA_WIDTH'(iPacket >> (int'(last_grant) * DATA_WIDTH));
  assign src_be = BE_WIDTH'(iByte_enable >> (int'(last_grant) * BE_WIDTH));
  assign oReady = (state == ARB_LOCKED) ? NUM_SOURCES'(1) << last_grant : '0;
`ifdef PACKET_ARBITER_TIMEOUT_EN
  logic [7:0] stall_cnt;
  logic timeout;
  assign timeout = (state == ARB_LOCKED) && !iValid[last_grant] && stall_cnt == 8'(TIMEOUT_CYCLES - 1);
`endif
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state <= ARB_IDLE;
      last_grant <= GW'(NUM_SOURCES - 1);
      oGrant <= '0;
      first <= 1'b0;
      oValid <= 1'b0;
      oPacket <= '0;
      oSop <= 1'b0;
      oEop <= 1'b0;
      oByte_enable <= '0;
      oProtocol_err <= 1'b0;
`ifdef PACKET_ARBITER_TIMEOUT_EN
      stall_cnt <= '0;
      oTimeout <= 1'b0;
`endif
    end else begin
      oValid <= xfer;
      oProtocol_err <= xfer && src_sop && !first;
      if (xfer) begin
        oPacket <= src_packet;
        oSop <= src_sop;
        oEop <= src_eop;
        oByte_enable <= src_be;
        first <= 1'b0;
      end
      if (state == ARB_IDLE && any_request) begin
        state <= ARB_LOCKED;
        last_grant <= pick;
        oGrant <= pick;
        first <= 1'b1;
      end else if (xfer && src_eop) begin
        state <= ARB_IDLE;
      end
`ifdef PACKET_ARBITER_TIMEOUT_EN
      oTimeout <= timeout;
      stall_cnt <= (state == ARB_LOCKED && !xfer) ? stall_cnt + 8'd1 : '0;
      // close the abandoned packet with an empty eop beat so the aligner flushes
      if (timeout) begin
        oValid <= 1'b1;
        oPacket <= '0;
        oSop <= 1'b0;
        oEop <= 1'b1;
        oByte_enable <= '0;
        stall_cnt <= '0;
        state <= ARB_IDLE;
      end
`endif
    end
  end
endmodule

// File: tb/tb_packet_arbiter.sv
// tb_packet_arbiter: directed and random packet traffic checked against a cycle-level round-robin reference model.
module tb_packet_arbiter;
  localparam int N = 4, DW = 32, BW = 4, GW = 2, T = 16;
  typedef struct {int len; int stall_at; int stall_len; int err_at; logic [BW-1:0] last_be;} pkt_t;
  logic clk = 1'b0, rst;
  logic [N-1:0] valid, sop, eop, ready;
  logic [N*DW-1:0] pkt;
  logic [N*BW-1:0] be;
  logic o_valid, o_sop, o_eop, o_err;
  logic [DW-1:0] o_pkt;
  logic [BW-1:0] o_be;
  logic [GW-1:0] o_grant;
`ifdef PACKET_ARBITER_TIMEOUT_EN
  logic o_tmo;
`endif
  always #5 clk = ~clk;
  packet_arbiter #(.NUM_SOURCES(N), .DATA_WIDTH(DW), .BE_WIDTH(BW), .TIMEOUT_CYCLES(T)) dut (
    .iClk(clk), .iReset(rst), .iValid(valid), .iPacket(pkt), .iSop(sop), .iEop(eop),
    .iByte_enable(be), .oReady(ready), .oValid(o_valid), .oPacket(o_pkt), .oSop(o_sop),
    .oEop(o_eop), .oByte_enable(o_be), .oGrant(o_grant),
`ifdef PACKET_ARBITER_TIMEOUT_EN
    .oTimeout(o_tmo),
`endif
    .oProtocol_err(o_err)
  );
  int n_chk = 0, n_fail = 0, err_seen = 0;
  pkt_t q[N][$];
  int cur_len[N], beat[N], stall_at[N], stall_left[N], err_at[N];
  logic [BW-1:0] last_be[N];
  bit junk[N];
  bit rnd_gap = 0;
  bit m_locked = 0, m_first = 0;
  int m_src = 0, m_last = N - 1, m_stall = 0;
  logic e_valid, e_sop, e_eop, e_err, e_tmo;
  logic [DW-1:0] e_pkt;
  logic [BW-1:0] e_be, last_out_be;
  logic [GW-1:0] e_grant;
  int gq[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add(int src, int len, int s_at, int s_len, int e_at, logic [BW-1:0] lbe);
    pkt_t p;
    p.len = len; p.stall_at = s_at; p.stall_len = s_len; p.err_at = e_at; p.last_be = lbe;
    q[src].push_back(p);
  endtask

  task automatic drive(bit r);
    rst = r;
    for (int i = 0; i < N; i++) begin
      if (cur_len[i] == 0 && q[i].size() > 0) begin
        pkt_t p;
        p = q[i].pop_front();
        cur_len[i] = p.len; beat[i] = 0; stall_at[i] = p.stall_at;
        stall_left[i] = p.stall_len; err_at[i] = p.err_at; last_be[i] = p.last_be;
      end
      valid[i] = cur_len[i] > 0;
      if (valid[i] && beat[i] == stall_at[i] && stall_left[i] > 0) begin
        valid[i] = 1'b0;
        stall_left[i]--;
      end else if (valid[i] && rnd_gap && $urandom_range(3) == 0) valid[i] = 1'b0;
      sop[i] = beat[i] == 0 || beat[i] == err_at[i];
      eop[i] = beat[i] == cur_len[i] - 1;
      if (junk[i] && cur_len[i] == 0) begin
        valid[i] = 1'b1; sop[i] = 1'b0; eop[i] = 1'b0;
      end
      pkt[i*DW +: DW] = $urandom;
      be[i*BW +: BW] = eop[i] ? last_be[i] : BW'($urandom);
    end
  endtask

  task automatic step(bit r);
    logic [N-1:0] er;
    drive(r);
    er = m_locked ? N'(1) << m_src : '0;
    chk("ready", ready, er);
    e_tmo = 1'b0;
    e_err = 1'b0;
    if (r) begin
      m_locked = 0; m_last = N - 1;
      e_valid = 0; e_sop = 0; e_eop = 0; e_pkt = '0; e_be = '0; e_grant = '0;
    end else if (m_locked) begin
      if (valid[m_src]) begin
        e_valid = 1; e_sop = sop[m_src]; e_eop = eop[m_src];
        e_pkt = DW'(pkt >> (m_src * DW)); e_be = BW'(be >> (m_src * BW));
        e_err = sop[m_src] && !m_first;
        m_first = 0; m_stall = 0; beat[m_src]++;
        if (eop[m_src]) begin m_locked = 0; cur_len[m_src] = 0; end
      end else begin
        e_valid = 0;
`ifdef PACKET_ARBITER_TIMEOUT_EN
        m_stall++;
        if (m_stall == T) begin
          e_valid = 1; e_sop = 0; e_eop = 1; e_be = '0; e_pkt = '0; e_tmo = 1;
          m_locked = 0; cur_len[m_src] = 0;
        end
`endif
      end
    end else begin
      e_valid = 0;
      for (int k = 1; k <= N; k++) begin
        int s;
        s = (m_last + k) % N;
        if (!m_locked && valid[s] && sop[s]) begin
          m_locked = 1; m_src = s; m_last = s; e_grant = GW'(s); m_first = 1; m_stall = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("valid", o_valid, e_valid);
    chk("grant", o_grant, e_grant);
    chk("perr", o_err, e_err);
    chk("packet", o_pkt, e_pkt);
    chk("byte_enable", o_be, e_be);
    if (e_valid) begin
      chk("sop", o_sop, e_sop);
      chk("eop", o_eop, e_eop);
    end
`ifdef PACKET_ARBITER_TIMEOUT_EN
    chk("timeout", o_tmo, e_tmo);
`endif
    if (o_valid === 1'b1 && o_sop === 1'b1) gq.push_back(int'(o_grant));
    if (o_valid === 1'b1 && o_eop === 1'b1) last_out_be = o_be;
    if (o_err === 1'b1) err_seen++;
  endtask

  function automatic bit busy();
    bit b;
    b = m_locked;
    for (int i = 0; i < N; i++) b = b || cur_len[i] > 0 || q[i].size() > 0;
    return b;
  endfunction

  task automatic run(string tag, int budget);
    int c;
    c = 0;
    do begin step(0); c++; end while (c < budget && busy());
    chk(tag, c < budget, 1);
    step(0);
    step(0);
  endtask

  task automatic order(string tag, int a, int b);
    chk(tag, gq.size(), (b < 0) ? 1 : 2);
    if (gq.size() > 0) chk(tag, gq[0], a);
    if (b >= 0 && gq.size() > 1) chk(tag, gq[1], b);
    gq.delete();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      cur_len[i] = 0; beat[i] = 0; stall_at[i] = -1; stall_left[i] = 0; err_at[i] = -1;
      last_be[i] = '0; junk[i] = 0;
    end
    rst = 1'b1; valid = '0; sop = '0; eop = '0; pkt = '0; be = '0;
    @(posedge clk);
    @(negedge clk);
    step(1);
    step(1);
    chk("reset_grant", o_grant, 0);
    gq.delete();
    add(0, 3, -1, 0, -1, 4'b0111);
    run("s1_drain", 50);
    order("s1_order", 0, -1);
    chk("s1_last_be", last_out_be, 4'b0111);
    add(1, 3, -1, 0, -1, 4'hf);
    add(2, 2, -1, 0, -1, 4'h3);
    run("s2_drain", 50);
    order("s2_order", 1, 2);
    add(1, 2, -1, 0, -1, 4'h1);
    add(3, 2, -1, 0, -1, 4'h7);
    run("s2b_drain", 50);
    order("s2b_order", 3, 1);
    add(2, 1, -1, 0, -1, 4'b0011);
    run("single_drain", 20);
    order("single_order", 2, -1);
    chk("single_be", last_out_be, 4'b0011);
    add(0, 4, 2, 5, -1, 4'h5);
    add(1, 2, -1, 0, -1, 4'h9);
    run("stall_drain", 60);
    order("stall_order", 0, 1);
    add(2, 3, 1, 100, -1, 4'hc);
    add(3, 2, -1, 0, -1, 4'h2);
    run("long_stall_drain", 300);
    order("long_stall_order", 2, 3);
    junk[1] = 1;
    add(3, 2, -1, 0, -1, 4'h6);
    run("junk_drain", 30);
    order("junk_order", 3, -1);
    junk[1] = 0;
    err_seen = 0;
    add(0, 4, -1, 0, 2, 4'h8);
    run("perr_drain", 30);
    chk("perr_count", err_seen, 1);
    gq.delete();
    add(0, 4, -1, 0, -1, 4'hf);
    for (int c = 0; c < 20 && (beat[0] != 2 || cur_len[0] == 0); c++) step(0);
    chk("rst_reach_beat2", beat[0], 2);
    step(1);
    cur_len[0] = 0;
    chk("rst_mid_valid", o_valid, 0);
    chk("rst_mid_ready", ready, 0);
    gq.delete();
    add(3, 1, -1, 0, -1, 4'h1);
    add(0, 1, -1, 0, -1, 4'h2);
    run("rst_after_drain", 30);
    order("rst_after_order", 0, 3);
    rnd_gap = 1;
    for (int n = 0; n < 80; n++) begin
      int len, e_at;
      len = $urandom_range(1, 6);
      e_at = (len > 1 && $urandom_range(7) == 0) ? $urandom_range(1, len - 1) : -1;
      add($urandom_range(N - 1), len, $urandom_range(0, len - 1), $urandom_range(0, 3), e_at, BW'($urandom));
    end
    run("random_drain", 5000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/packet_arbiter.md
Name: packet_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one payload_aligner input stream between NUM_SOURCES packet sources.
- Each source presents the packet stream signals (valid/data/sop/eop/byte_enable) with a ready back-pressure.
- The arbiter locks onto one source from sop to eop, then re-arbitrates.
- Its registered output drives payload_aligner iValid/iPacket/iSop/iEop/iByte_enable directly. The aligner has no back-pressure.

Parameters:
- NUM_SOURCES, 4, number of requesters; range 2..16.
- DATA_WIDTH, packet_pkg::packet_width_bits, beat width in bits.
- BE_WIDTH, packet_pkg::byte_enable_width_bits, byte-enable width.
- TIMEOUT_CYCLES, 16, stall limit for the optional watchdog; range 2..255.

Ports:
- iClk  in  1  clock; single clock domain.
- iReset  in  1  synchronous, active-high reset.
- iValid  in  NUM_SOURCES  per-source beat valid.
- iPacket  in  NUM_SOURCES*DATA_WIDTH  per-source beat data; source i occupies slice i.
- iSop  in  NUM_SOURCES  per-source start of packet.
- iEop  in  NUM_SOURCES  per-source end of packet.
- iByte_enable  in  NUM_SOURCES*BE_WIDTH  per-source byte enables; valid on eop beats only.
- oReady  out  NUM_SOURCES  per-source ready; a beat transfers when iValid[i] & oReady[i].
- oValid  out  1  output beat valid.
- oPacket  out  DATA_WIDTH  output beat data.
- oSop  out  1  output start of packet.
- oEop  out  1  output end of packet.
- oByte_enable  out  BE_WIDTH  output byte enables.
- oGrant  out  $clog2(NUM_SOURCES)  index of the currently or last granted source.
- oProtocol_err  out  1  one-cycle pulse on an illegal sop.

Behaviour:
- Reset values (synchronous on iReset=1): all outputs 0, state ARB_IDLE, last_grant=NUM_SOURCES-1 so source 0 has highest priority.
- A source requests when iValid[i]=1 and iSop[i]=1. iValid without iSop in ARB_IDLE is not a request; that beat is held (oReady=0) and ignored.
- ARB_IDLE:
  - All oReady=0.
  - If any request exists, pick the first requester searching from (last_grant+1) mod NUM_SOURCES upward with wrap.
  - Register grant into oGrant and last_grant. Go to ARB_LOCKED.
- ARB_LOCKED:
  - oReady[grant]=1, all other oReady=0. oReady is combinational from state and grant.
  - Each transferred beat is registered to the outputs one cycle later: oValid=1, and oPacket/oSop/oEop/oByte_enable copy the source signals.
  - If no beat transfers, oValid=0 and the data outputs hold their last value.
  - A transfer with iEop=1 returns the arbiter to ARB_IDLE on the next cycle. A single-beat packet (iSop & iEop) is legal.
- Latency: request seen → 1 arbitration cycle → oReady high → beat appears on the outputs 1 cycle after transfer.
  - There is a minimum 1-cycle oValid gap between consecutive packets, because the eop beat is followed by an ARB_IDLE cycle.
- Protocol error:
  - Condition: a transferred beat in ARB_LOCKED with iSop=1 that is not the first beat of the packet.
  - oProtocol_err pulses for one cycle, aligned with that beat's output cycle. The beat is forwarded unchanged.
- Requests from non-granted sources never affect the granted stream. Losers keep iValid/iSop asserted and wait.
- Stall handling (granted source drops iValid mid-packet): the arbiter stays in ARB_LOCKED indefinitely unless PACKET_ARBITER_TIMEOUT_EN is defined.
- Reset mid-packet:
  - The next cycle has all outputs 0 and oReady=0, and the state is ARB_IDLE.
  - The partial packet is abandoned with no eop generated.

Optional Feature:
- Macro: PACKET_ARBITER_TIMEOUT_EN.
- Defined:
  - Adds a watchdog counter in ARB_LOCKED. It clears on every transfer and increments on every cycle with iValid[grant]=0.
  - When the counter reaches TIMEOUT_CYCLES, the arbiter emits one terminating beat: oValid=1, oEop=1, oSop=0, oByte_enable='0, oPacket='0.
  - On that same output cycle it pulses an extra port, oTimeout (out, 1), for one cycle.
  - It then returns to ARB_IDLE. The grant moves on and the stalled source loses the lock.
- Not defined: no counter, no oTimeout port, and stalls are unbounded.

Decomposition:
- packet_arbiter_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_LOCKED}.
  - Default NUM_SOURCES and TIMEOUT_CYCLES constants.
  - The grant-index width constant.
- It imports packet_pkg for the widths.
- One sub-module: round_robin_picker, combinational.
  - Inputs: request vector and last_grant.
  - Outputs: grant index and any_request.
  - It is reused by later schedulers.

Test Plan:
- Source 0 sends a 3-beat packet with last be=4'b0111 → oReady[0] rises the cycle after the request. Three output beats follow, each one cycle after its transfer. oSop is on beat 1; oEop with oByte_enable=4'b0111 is on beat 3; oGrant=0.
- Sources 1 and 2 request in the same cycle after reset → source 1 is granted first and source 2 after source 1's eop plus 1 idle cycle. Then sources 1 and 3 request together → source 3 wins because the pointer is past 2.
- Single-beat packet on source 2 (iSop=iEop=1, be=4'b0011) → one output beat with oSop=oEop=1; ARB_IDLE the next cycle.
- Granted source drops iValid for 5 cycles mid-packet with a competing request present → 5 oValid=0 cycles, no grant change, all beats delivered in order.
- iReset asserted during beat 2 of a 4-beat packet → the next cycle has all outputs 0 and oReady=0; after release, source 0 has top priority.
- With PACKET_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=16, stall the granted source 16 cycles → terminating beat (oEop=1, oByte_enable=0) plus an oTimeout pulse, then the next requester is granted. Without the macro, the lock is held for 100 stall cycles.
